rcpfa_pipe_adder: RTL and testbench
===================================

// Module: rcpfa_pipe_adder
// PURPOSE
//  Parametrised, pipelined approximate adder built on the carry-predicting
//  full-adder cell. The low APPROX_BITS use the predicted carry (the previous
//  bit's generate) instead of the rippled carry; the upper bits are exact.
//  A per-transaction mode selects exact or approximate. A valid/ready
//  handshake is provided on both sides. An on-line error monitor flags and
//  counts inexact results. Sits between operand sources and accuracy/quality
//  evaluation logic.
// PARAMETERS
//  WIDTH        16  operand/sum width (>=2)
//  APPROX_BITS  4   number of approximate LSBs, 0..WIDTH (0 => always exact)
//  STAGES       2   pipeline depth in register stages (>=1) = latency
//  ERR_CNT_W    16  error counter width
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous active-high reset
//  in_valid   in   1          operand beat valid
//  in_ready   out  1          block accepts operand beat
//  a          in   WIDTH      operand A
//  b          in   WIDTH      operand B
//  mode       in   1          0 = exact, 1 = approximate (sampled with operands)
//  out_valid  out  1          result beat valid
//  out_ready  in   1          downstream accepts result
//  sum        out  WIDTH      result sum
//  cout       out  1          result carry-out
//  err_flag   out  1          this result differs from exact {cout,sum}
//  err_count  out  ERR_CNT_W  saturating count of accepted results with err_flag
//  clr_err    in   1          synchronous clear of err_count
// BEHAVIOUR
//  - Approx arithmetic, k = APPROX_BITS: g[i] = a[i]&b[i]; p0 = 0.
//    For i < k: sum[i] = a[i]^b[i]^(i==0 ? 0 : g[i-1]).
//    The carry into bit k is g[k-1]; bits k..WIDTH-1 and cout are the exact
//    ripple of a[W-1:k] + b[W-1:k] + g[k-1].
//  - Exact arithmetic: {cout,sum} = a + b (WIDTH+1 bits).
//  - err_flag = (mode==1) && (approx {cout,sum} != exact {cout,sum}).
//    err_flag is always 0 in exact mode and always 0 when k = 0.
//  - Pipeline: STAGES register stages, each holding a valid bit plus payload.
//    Stage advance enable: en = ~out_valid | out_ready.
//    in_ready = en (combinational). Transfer occurs on in_valid & in_ready.
//    Latency is exactly STAGES cycles from acceptance to out_valid with no
//    stall. Stalls freeze every stage. Bubbles propagate as valid = 0.
//    Beats are never dropped, duplicated or reordered. Carry logic may be
//    split across stages as long as results match the arithmetic above.
//  - Outputs are held stable while out_valid & ~out_ready.
//  - err_count increments by 1 on (out_valid & out_ready & err_flag).
//    It saturates at all-ones. clr_err sets it to 0 and wins over a
//    same-cycle increment.
//  - Reset (asynchronous, any time, including mid-stream):
//    all stage valids = 0, out_valid = 0, sum = 0, cout = 0, err_flag = 0,
//    err_count = 0. In-flight beats are discarded. in_ready = 1 after reset.
// TESTING (WIDTH=16, APPROX_BITS=4, STAGES=2 unless stated)
//  1. mode=0, a=FFFF, b=0001 -> 2 cycles later: sum=0000, cout=1, err_flag=0.
//  2. mode=1, a=0003, b=0001 -> sum=0000, cout=0, err_flag=1, err_count=1.
//     mode=1, a=000F, b=0001 -> sum=000C, err_count=2.
//     mode=1, a=FFFF, b=0001 -> sum=FFFC, cout=0, err_flag=1.
//  3. mode=1, a=00F0, b=0010 -> sum=0100, err_flag=0 (exact upper carry).
//     The same operands with APPROX_BITS=0 match the exact result for 1000
//     random vectors.
//  4. Back-to-back stream of 20 beats with out_ready toggled randomly ->
//     in-order, lossless outputs matching the model; outputs are stable
//     during stalls; throughput is 1 beat/cycle when out_ready=1.
//  5. ERR_CNT_W=2, 5 erroneous accepted beats -> err_count sticks at 3.
//     clr_err together with an erroneous accept -> err_count=0.
//  6. Assert rst while 2 beats are in flight -> out_valid=0 and
//     err_count=0 immediately; no stale beat emerges after rst deasserts.

Source files
------------

// File: rtl/rcpfa_pipe_adder.sv
// Pipelined approximate adder using carry-predicting full-adder cells in the low
// APPROX_BITS, with valid/ready handshake and an on-line inexact-result monitor.
module rcpfa_pipe_adder #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 4,
    parameter int STAGES      = 2,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     sum,
    output logic                 cout,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clr_err
);
    localparam int K = APPROX_BITS;

    logic [WIDTH:0] approx_res;
    logic [WIDTH:0] exact_res;
    logic [WIDTH:0] res_in;
    logic           carry_k;
    logic           is_err;

    // Each low bit takes the previous bit's generate as its carry instead of
    // the rippled one, so the low region has no carry chain at all.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_approx_bit
            if (gi == 0) begin : g_lsb
                assign approx_res[gi] = a[gi] ^ b[gi];
            end else begin : g_pred
                assign approx_res[gi] = a[gi] ^ b[gi] ^ (a[gi-1] & b[gi-1]);
            end
        end

        if (K == 0) begin : g_no_pred_carry
            assign carry_k = 1'b0;
        end else begin : g_pred_carry
            assign carry_k = a[K-1] & b[K-1];
        end

        if (K < WIDTH) begin : g_exact_upper
            assign approx_res[WIDTH:K] = {1'b0, a[WIDTH-1:K]} + {1'b0, b[WIDTH-1:K]}
                                       + {{(WIDTH-K){1'b0}}, carry_k};
        end else begin : g_all_approx
            assign approx_res[WIDTH] = carry_k;
        end
    endgenerate

    assign exact_res = {1'b0, a} + {1'b0, b};
    assign is_err    = mode & (approx_res != exact_res);
    assign res_in    = mode ? approx_res : exact_res;

    logic [STAGES-1:0]            vld_q, vld_d;
    logic [STAGES-1:0]            err_q, err_d;
    logic [STAGES-1:0][WIDTH:0]   res_q, res_d;
    logic [ERR_CNT_W-1:0]         cnt_q, cnt_d;
    logic                         en;
    logic                         out_fire;

    // A single global enable freezes every stage while the output is stalled.
    assign en       = ~vld_q[STAGES-1] | out_ready;
    assign in_ready = en;
    assign out_fire = vld_q[STAGES-1] & out_ready;

    always_comb begin
        vld_d = vld_q;
        err_d = err_q;
        res_d = res_q;
        if (en) begin
            vld_d[0] = in_valid;
            err_d[0] = in_valid & is_err;
            res_d[0] = res_in;
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                err_d[i] = err_q[i-1];
                res_d[i] = res_q[i-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_err) begin
            cnt_d = '0;
        end else if (out_fire && err_q[STAGES-1] && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = res_q[STAGES-1][WIDTH-1:0];
    assign cout      = res_q[STAGES-1][WIDTH];
    assign err_flag  = err_q[STAGES-1];
    assign err_count = cnt_q;

endmodule

// File: tb/tb_rcpfa_pipe_adder.sv
// Directed and streamed checks of rcpfa_pipe_adder against a bench-side
// arithmetic model; three instances share stimulus (default, exact-only, 2-bit counter).
module tb_rcpfa_pipe_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_err = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        m_in_ready, m_valid, m_cout, m_err;
    logic [15:0] m_sum, m_cnt;
    logic        x_in_ready, x_valid, x_cout, x_err;
    logic [15:0] x_sum, x_cnt;
    logic        s_in_ready, s_valid, s_cout, s_err;
    logic [15:0] s_sum;
    logic [1:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rcpfa_pipe_adder #(.WIDTH(16), .APPROX_BITS(4), .STAGES(2), .ERR_CNT_W(16)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .a(a), .b(b),
        .mode(mode), .out_valid(m_valid), .out_ready(out_ready), .sum(m_sum), .cout(m_cout),
        .err_flag(m_err), .err_count(m_cnt), .clr_err(clr_err));

    rcpfa_pipe_adder #(.WIDTH(16), .APPROX_BITS(0), .STAGES(2), .ERR_CNT_W(16)) u_exact (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_in_ready), .a(a), .b(b),
        .mode(mode), .out_valid(x_valid), .out_ready(out_ready), .sum(x_sum), .cout(x_cout),
        .err_flag(x_err), .err_count(x_cnt), .clr_err(clr_err));

    rcpfa_pipe_adder #(.WIDTH(16), .APPROX_BITS(4), .STAGES(2), .ERR_CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
        .mode(mode), .out_valid(s_valid), .out_ready(out_ready), .sum(s_sum), .cout(s_cout),
        .err_flag(s_err), .err_count(s_cnt), .clr_err(clr_err));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Low 4 bits use the neighbour's generate as carry-in; upper 12 bits add
    // exactly with g[3] as carry-in.
    function automatic logic [16:0] approx_model(input logic [15:0] av, input logic [15:0] bv);
        logic [16:0] r;
        logic [12:0] up;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i] = av[i] ^ bv[i] ^ ((i == 0) ? 1'b0 : (av[i-1] & bv[i-1]));
        end
        up = {1'b0, av[15:4]} + {1'b0, bv[15:4]} + {12'd0, av[3] & bv[3]};
        r[16:4] = up;
        return r;
    endfunction

    function automatic logic [16:0] exact_model(input logic [15:0] av, input logic [15:0] bv);
        return {1'b0, av} + {1'b0, bv};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic m, input logic [15:0] av, input logic [15:0] bv);
        mode = m;
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        $display("beat mode=%0d a=%h b=%h -> valid=%b sum=%h cout=%b err=%b cnt=%0d",
                 m, av, bv, m_valid, m_sum, m_cout, m_err, m_cnt);
    endtask

    task automatic run_stream(input int n, input bit rnd_ready, input bit chk_thru);
        logic [16:0] q_m[$];
        logic [16:0] q_x[$];
        logic        q_e[$];
        logic [16:0] em, ex;
        logic        ee;
        logic [31:0] r32;
        logic [15:0] na, nb;
        logic        nm, hold, accept;
        logic [18:0] held;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        hold = 1'b0;
        held = '0;
        r32 = $urandom; na = r32[15:0]; nb = r32[31:16];
        r32 = $urandom; nm = r32[0];
        while (got < n && cyc < n * 20 + 50) begin
            if (rnd_ready) begin
                r32 = $urandom;
                out_ready = r32[0];
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (sent < n);
            a = na;
            b = nb;
            mode = nm;
            #1;
            if (hold) check("stall_hold", {13'd0, m_valid, m_cout, m_err, m_sum}, {13'd0, held});
            if (m_valid && !out_ready) check("stall_in_ready", {31'd0, m_in_ready}, 32'd0);
            if (chk_thru) check("thru_in_ready", {31'd0, m_in_ready}, 32'd1);
            if (m_valid && out_ready) begin
                if (q_m.size() == 0) begin
                    check("stream_extra_beat", 32'd1, 32'd0);
                end else begin
                    em = q_m.pop_front();
                    ex = q_x.pop_front();
                    ee = q_e.pop_front();
                    check("stream_sum", {15'd0, m_cout, m_sum}, {15'd0, em});
                    check("stream_err", {31'd0, m_err}, {31'd0, ee});
                    check("exact_inst_sum", {15'd0, x_cout, x_sum}, {15'd0, ex});
                    check("exact_inst_err", {31'd0, x_err}, 32'd0);
                end
                got++;
            end
            hold = m_valid & ~out_ready;
            held = {1'b1, m_cout, m_err, m_sum};
            accept = in_valid & m_in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (accept) begin
                em = nm ? approx_model(na, nb) : exact_model(na, nb);
                ex = exact_model(na, nb);
                q_m.push_back(em);
                q_x.push_back(ex);
                q_e.push_back(nm && (approx_model(na, nb) != ex));
                sent++;
                r32 = $urandom; na = r32[15:0]; nb = r32[31:16];
                r32 = $urandom; nm = r32[0];
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got, n);
        if (chk_thru) check("thru_cycles", cyc, n + 2);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_out_valid", {31'd0, m_valid}, 32'd0);
        check("rst_sum", {15'd0, m_cout, m_sum}, 32'd0);
        check("rst_err_flag", {31'd0, m_err}, 32'd0);
        check("rst_err_count", {16'd0, m_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, m_in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        send(1'b0, 16'hFFFF, 16'h0001);
        check("t1_valid", {31'd0, m_valid}, 32'd1);
        check("t1_sum", {15'd0, m_cout, m_sum}, 32'h10000);
        check("t1_err", {31'd0, m_err}, 32'd0);

        send(1'b1, 16'h0003, 16'h0001);
        check("t2a_sum", {15'd0, m_cout, m_sum}, 32'h00000);
        check("t2a_err", {31'd0, m_err}, 32'd1);
        tick();
        check("t2a_cnt", {16'd0, m_cnt}, 32'd1);
        send(1'b1, 16'h000F, 16'h0001);
        check("t2b_sum", {15'd0, m_cout, m_sum}, 32'h0000C);
        tick();
        check("t2b_cnt", {16'd0, m_cnt}, 32'd2);
        send(1'b1, 16'hFFFF, 16'h0001);
        check("t2c_sum", {15'd0, m_cout, m_sum}, 32'h0FFFC);
        check("t2c_err", {31'd0, m_err}, 32'd1);
        tick();
        check("t2c_cnt", {16'd0, m_cnt}, 32'd3);

        send(1'b1, 16'h00F0, 16'h0010);
        check("t3_sum", {15'd0, m_cout, m_sum}, 32'h00100);
        check("t3_err", {31'd0, m_err}, 32'd0);
        check("t3_exact_inst", {15'd0, x_cout, x_sum}, 32'h00100);
        tick();
        check("t3_cnt", {16'd0, m_cnt}, 32'd3);

        do_reset();
        for (int i = 0; i < 5; i++) send(1'b1, 16'h0003, 16'h0001);
        tick();
        check("t5_small_sat", {30'd0, s_cnt}, 32'd3);
        check("t5_main_cnt", {16'd0, m_cnt}, 32'd5);
        send(1'b1, 16'h0003, 16'h0001);
        check("t5_clr_beat_err", {31'd0, m_err}, 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t5_clr_small", {30'd0, s_cnt}, 32'd0);
        check("t5_clr_main", {16'd0, m_cnt}, 32'd0);

        run_stream(1000, 1'b0, 1'b1);
        run_stream(20, 1'b1, 1'b0);

        out_ready = 1'b0;
        mode = 1'b1;
        a = 16'h0003;
        b = 16'h0001;
        in_valid = 1'b1;
        tick();
        a = 16'h000F;
        tick();
        in_valid = 1'b0;
        check("t6_inflight_valid", {31'd0, m_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, m_valid}, 32'd0);
        check("t6_rst_sum", {15'd0, m_cout, m_sum}, 32'd0);
        check("t6_rst_err", {31'd0, m_err}, 32'd0);
        check("t6_rst_cnt", {16'd0, m_cnt}, 32'd0);
        check("t6_rst_in_ready", {31'd0, m_in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_no_stale", {31'd0, m_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
